// File: rtl/div_seq_if.sv
// Handshake and result bundle for the div_seq sequential divider.
// Optional macro: DIV_ZERO_DETECT_EN adds the div_zero flag.
interface div_seq_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic        div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/div_seq.sv
// Sequential signed 32/32 divider: unsigned restoring core on operand
// magnitudes (32 steps), followed by a sign fix-up edge.
// Optional macro: DIV_ZERO_DETECT_EN short-cuts divide-by-zero to the
// fix-up state and raises div_zero.
module div_seq (
  input  logic      clk,
  input  logic      clear,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        sign_n_q, sign_d_q;
  logic [31:0] quotient_q, remainder_q;
  logic        done_q;
`ifdef DIV_ZERO_DETECT_EN
  logic        dz_q, div_zero_q;
`endif

  logic [31:0] rem_sh;
  logic [32:0] diff;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) begin
`ifdef DIV_ZERO_DETECT_EN
        state_next = (bus.divisor == '0) ? FIX : CALC;
`else
        state_next = CALC;
`endif
      end
      CALC:    if (cnt_q == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift next dividend bit in, trial-subtract divisor.
  always_comb begin
    rem_sh = {rem_q[30:0], quo_q[31]};
    diff   = {1'b0, rem_sh} - {1'b0, dvs_q};
  end

  // Datapath: operand capture, iteration, sign fix-up and result hold.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      sign_n_q    <= 1'b0;
      sign_d_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q        <= 1'b0;
      div_zero_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          rem_q    <= '0;
          quo_q    <= mag32(bus.dividend);
          dvs_q    <= mag32(bus.divisor);
          sign_n_q <= bus.dividend[31];
          sign_d_q <= bus.divisor[31];
          cnt_q    <= '0;
`ifdef DIV_ZERO_DETECT_EN
          dz_q       <= (bus.divisor == '0);
          div_zero_q <= 1'b0;
`endif
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= rem_sh;
            quo_q <= {quo_q[30:0], 1'b0};
          end
        end
        FIX: begin
          done_q <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          if (dz_q) begin
            // No iterations ran, so quo_q still holds |dividend|.
            quotient_q  <= '1;
            remainder_q <= sign_n_q ? neg32(quo_q) : quo_q;
            div_zero_q  <= 1'b1;
          end else begin
            quotient_q  <= (sign_n_q ^ sign_d_q) ? neg32(quo_q) : quo_q;
            remainder_q <= sign_n_q ? neg32(rem_q) : rem_q;
          end
`else
          quotient_q  <= (sign_n_q ^ sign_d_q) ? neg32(quo_q) : quo_q;
          remainder_q <= sign_n_q ? neg32(rem_q) : rem_q;
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = done_q;
    bus.quotient  = quotient_q;
    bus.remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    bus.div_zero  = div_zero_q;
`endif
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, multi-cycle
// corner sequences and randomized operands against an arithmetic model.
module tb_div_seq;

  logic clk = 1'b0;
  logic clear;

  div_seq_if dif();

  div_seq dut (
    .clk   (clk),
    .clear (clear),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating signed division done in 64-bit so INT_MIN/-1 wraps.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    lat = 34;
    if (b == 32'd0) begin
      r = a;
`ifdef DIV_ZERO_DETECT_EN
      q = 32'hFFFF_FFFF;
      dz = 1'b1;
      lat = 2;
`else
      q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
`endif
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Issue one operation; returns when done is seen (bounded).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit now,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int lat, output int busy_bad);
    if (!now) @(negedge clk);
    dif.start = 1'b1;
    dif.dividend = a;
    dif.divisor = b;
    @(negedge clk);
    dif.start = 1'b0;
    dif.dividend = $urandom;
    dif.divisor = $urandom;
    lat = 1;
    busy_bad = 0;
    while (dif.done !== 1'b1 && lat < 200) begin
      if (dif.busy !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    q = dif.quotient;
    r = dif.remainder;
`ifdef DIV_ZERO_DETECT_EN
    dz = dif.div_zero;
`else
    dz = 1'b0;
`endif
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input bit now, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat);
    logic [31:0] q, r;
    logic dz;
    int lat, bb;
    do_op(a, b, now, q, r, dz, lat, bb);
    if (lat != elat)
      $display("FAIL %s_latency: got %0d expected %0d (a=%h b=%h)", name, lat, elat, a, b);
    checks++;
    if (lat != elat) errors++;
    chk({name, "_q"}, q, eq);
    chk({name, "_r"}, r, er);
    chk({name, "_busy_gap"}, 32'(bb), 32'd0);
    chk({name, "_busy_at_done"}, {31'd0, dif.busy}, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    chk({name, "_dz"}, {31'd0, dz}, {31'd0, edz});
`else
    if (edz) $display("note: divide-by-zero flag not built");
`endif
  endtask

  initial begin
    logic [31:0] mq, mr;
    logic mdz;
    int mlat, seen, cnt;

    tbl[0]  = '{32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002};
    tbl[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE};
    tbl[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2, 32'h0000_0002};
    tbl[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000};
    tbl[4]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[5]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001};
    tbl[6]  = '{32'd0,          32'd5,          32'h0000_0000, 32'h0000_0000};
    tbl[7]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF, 32'h0000_0000};
    tbl[8]  = '{32'd5,          32'h8000_0000,  32'h0000_0000, 32'h0000_0005};
    tbl[9]  = '{32'h8000_0000,  32'h8000_0000,  32'h0000_0001, 32'h0000_0000};
    tbl[10] = '{32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'h0000_0000, 32'hFFFF_FFFF};

    clear = 1'b1;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, dif.busy}, 32'd0);
    chk("reset_done", {31'd0, dif.done}, 32'd0);
    chk("reset_q", dif.quotient, 32'd0);
    chk("reset_r", dif.remainder, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    chk("reset_dz", {31'd0, dif.div_zero}, 32'd0);
`endif
    clear = 1'b0;

    // Directed table; each result must hold after the one-cycle done pulse.
    for (int i = 0; i < 11; i++) begin
      run_check("vec", tbl[i].a, tbl[i].b, 1'b0, tbl[i].q, tbl[i].r, 1'b0, 34);
      repeat (2) @(negedge clk);
      chk("done_pulse_width", {31'd0, dif.done}, 32'd0);
      chk("q_hold", dif.quotient, tbl[i].q);
      chk("r_hold", dif.remainder, tbl[i].r);
    end

    // Divide by zero behaviour of the current build.
`ifdef DIV_ZERO_DETECT_EN
    run_check("dz_pos", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
    repeat (3) @(negedge clk);
    chk("dz_hold", {31'd0, dif.div_zero}, 32'd1);
    run_check("dz_neg", 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);
    run_check("dz_cleared", 32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'h0000_0002, 1'b0, 34);
`else
    run_check("dz_pos", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 34);
    run_check("dz_neg", 32'hFFFF_FFFB, 32'd0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFB, 1'b0, 34);
`endif

    // Start while busy is ignored and does not disturb operands in flight.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    cnt = 11;
    while (dif.done !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("ignored_start_latency", 32'(cnt), 32'd34);
    chk("ignored_start_q", dif.quotient, 32'd10);
    chk("ignored_start_r", dif.remainder, 32'd0);
    @(negedge clk);
    chk("ignored_start_not_rerun", {31'd0, dif.busy}, 32'd0);

    // Clear mid-operation aborts without done; outputs drop immediately.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 clear = 1'b1;
    #1;
    chk("abort_busy", {31'd0, dif.busy}, 32'd0);
    chk("abort_done", {31'd0, dif.done}, 32'd0);
    chk("abort_q", dif.quotient, 32'd0);
    chk("abort_r", dif.remainder, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
    end
    chk("abort_no_activity", 32'(seen), 32'd0);
    run_check("after_clear", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);

    // Back-to-back: start held during the done cycle, next done 34 cycles on.
    run_check("b2b_first", 32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'h0000_0002, 1'b0, 34);
    run_check("b2b_second", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0 - 32'($urandom_range(1, 20));
        3: b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      ref_div(a, b, mq, mr, mdz, mlat);
      run_check("rand", a, b, 1'b0, mq, mr, mdz, mlat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, and all state SHALL change on the rising clk edge.
REQ-002 clk  input  1  system clock.
REQ-003 clear  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  32  signed two's-complement dividend.
REQ-006 divisor  input  32  signed two's-complement divisor.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quotient  output  32  signed quotient (LO).
REQ-010 remainder  output  32  signed remainder (HI).
REQ-011 div_zero  output  1  divide-by-zero flag; present only when DIV_ZERO_DETECT_EN is defined.

Function
REQ-012 States SHALL be IDLE, CALC and FIX; IDLE->CALC on start=1, CALC->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-013 On the accepting edge T0, operands SHALL be captured as magnitudes (two's-complement negate when bit 31 = 1), the operand sign bits latched, the 5-bit iteration counter zeroed and busy set.
REQ-014 Edges T1..T32 SHALL each perform one unsigned restoring step: shift {rem,quo} left 1, trial-subtract |divisor|, keep the result and set the quotient LSB to 1 when non-negative, otherwise restore.
REQ-015 Edge T33 (FIX) SHALL negate quotient when the sign bits differ and negate remainder when the dividend is negative, load quotient and remainder, set done=1 and clear busy.
REQ-016 done SHALL be high for exactly the single cycle after T33 and low otherwise.
REQ-017 quotient and remainder SHALL hold their values until the next FIX edge or until clear.
REQ-018 Division SHALL truncate toward zero, the remainder SHALL take the dividend's sign, and |remainder| < |divisor| SHALL hold for divisor != 0.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-020 start while busy=1 SHALL be ignored, and the operands in flight SHALL be unaffected.
REQ-021 start=1 in the cycle in which done=1 SHALL be accepted, because the state is IDLE; done then falls and busy rises at that edge.
REQ-022 dividend and divisor SHALL be don't-care except at the accepting edge.

Reset
REQ-023 clear=1 SHALL immediately force IDLE and drive busy=0, done=0, quotient=0, remainder=0, div_zero=0 and counter=0, regardless of the clock.
REQ-024 clear asserted mid-operation SHALL abort the operation without producing a done pulse; the first start after clear deasserts SHALL behave as from power-up.

Configuration
REQ-025 Macro DIV_ZERO_DETECT_EN defined: start with divisor=0 SHALL go IDLE->FIX directly, producing done at the T1 edge with div_zero=1, quotient=0xFFFFFFFF and remainder=dividend; div_zero SHALL clear on the next accepted start.
REQ-026 Macro undefined: the div_zero port SHALL be absent and divisor=0 SHALL run the full 33-edge sequence, producing quotient=0xFFFFFFFF (dividend >= 0) or 0x00000001 (dividend < 0) and remainder=dividend.

Verification
REQ-027 100 / 7, start at T0 -> busy T0..T33; done only after T33; quotient=0x0000000E, remainder=0x00000002.
REQ-028 -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; then 100 / -7 -> quotient=0xFFFFFFF2, remainder=0x00000002.
REQ-029 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0x00000000.
REQ-030 0x12345678 / 0 in both builds -> per REQ-025 (done at T1, div_zero=1) and REQ-026 (done at T33, quotient=0xFFFFFFFF, remainder=0x12345678).
REQ-031 Start 50/5, pulse start with 9/3 at T10, pulse clear at T20 -> no done, outputs 0; restart 9/3 -> quotient=3, remainder=0.
REQ-032 Back-to-back runs, with start held high during the done cycle -> second operation accepted, second done exactly 34 cycles after the first.
